// File: rtl/iclark_tr.sv
// Inverse Clarke transform, amplitude-invariant form, 3-stage pipeline with
// a symmetric per-phase output clamp and a saturation flag.
module iclark_tr #(
  parameter int unsigned OUT_LIM = 8191,
  parameter int unsigned K_S3H   = 28378
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_en,
  input  logic signed [15:0] i_ialpha,
  input  logic signed [15:0] i_ibeta,
  output logic               o_en,
  output logic signed [15:0] o_ia,
  output logic signed [15:0] o_ib,
  output logic signed [15:0] o_ic,
  output logic               o_sat
);

  localparam logic signed [31:0] KCoef = 32'(K_S3H);
  localparam logic signed [17:0] LimP  = 18'(OUT_LIM);
  localparam logic signed [17:0] LimN  = -LimP;

  function automatic logic signed [15:0] clamp_val(input logic signed [17:0] x);
    if (x > LimP) begin
      return LimP[15:0];
    end else if (x < LimN) begin
      return LimN[15:0];
    end else begin
      return x[15:0];
    end
  endfunction

  function automatic logic clamp_hit(input logic signed [17:0] x);
    return (x > LimP) || (x < LimN);
  endfunction

  // Stage 1 state
  logic signed [15:0] a1_q, a1_d;
  logic signed [15:0] h1_q, h1_d;
  logic signed [31:0] p1_q, p1_d;
  logic               en1_q, en1_d;

  // Stage 2 state
  logic signed [15:0] a2_q, a2_d;
  logic signed [17:0] b2_q, b2_d;
  logic signed [17:0] c2_q, c2_d;
  logic               en2_q, en2_d;

  // Stage 3 (output) state
  logic signed [15:0] ia_q, ia_d;
  logic signed [15:0] ib_q, ib_d;
  logic signed [15:0] ic_q, ic_d;
  logic               sat_q, sat_d;
  logic               oen_q, oen_d;

  logic signed [31:0] beta_ext;
  logic signed [32:0] p_rnd;
  logic signed [17:0] bt;
  logic signed [17:0] h1_ext;
  logic signed [17:0] a1_ext;
  logic signed [17:0] a2_ext;
  logic               unused_lsb;

  always_comb begin
    beta_ext = {{16{i_ibeta[15]}}, i_ibeta};
    a1_d     = i_ialpha;
    h1_d     = i_ialpha >>> 1;
    p1_d     = beta_ext * KCoef;
    en1_d    = i_en;
  end

  // Round half up: add half an LSB of Q15, then floor by taking the upper bits.
  always_comb begin
    p_rnd  = {p1_q[31], p1_q} + 33'sd16384;
    bt     = p_rnd[32:15];
    h1_ext = {{2{h1_q[15]}}, h1_q};
    a1_ext = {{2{a1_q[15]}}, a1_q};
    b2_d   = bt - h1_ext;
    c2_d   = -a1_ext - b2_d;
    a2_d   = a1_q;
    en2_d  = en1_q;
  end

  assign unused_lsb = ^p_rnd[14:0];

  // Outputs only update on a valid sample so consumers see stable values between pulses.
  always_comb begin
    a2_ext = {{2{a2_q[15]}}, a2_q};
    oen_d  = en2_q;
    ia_d   = ia_q;
    ib_d   = ib_q;
    ic_d   = ic_q;
    sat_d  = sat_q;
    if (en2_q) begin
      ia_d  = clamp_val(a2_ext);
      ib_d  = clamp_val(b2_q);
      ic_d  = clamp_val(c2_q);
      sat_d = clamp_hit(a2_ext) | clamp_hit(b2_q) | clamp_hit(c2_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a1_q  <= '0;
      h1_q  <= '0;
      p1_q  <= '0;
      en1_q <= 1'b0;
      a2_q  <= '0;
      b2_q  <= '0;
      c2_q  <= '0;
      en2_q <= 1'b0;
      ia_q  <= '0;
      ib_q  <= '0;
      ic_q  <= '0;
      sat_q <= 1'b0;
      oen_q <= 1'b0;
    end else begin
      a1_q  <= a1_d;
      h1_q  <= h1_d;
      p1_q  <= p1_d;
      en1_q <= en1_d;
      a2_q  <= a2_d;
      b2_q  <= b2_d;
      c2_q  <= c2_d;
      en2_q <= en2_d;
      ia_q  <= ia_d;
      ib_q  <= ib_d;
      ic_q  <= ic_d;
      sat_q <= sat_d;
      oen_q <= oen_d;
    end
  end

  assign o_en  = oen_q;
  assign o_ia  = ia_q;
  assign o_ib  = ib_q;
  assign o_ic  = ic_q;
  assign o_sat = sat_q;

endmodule
